mux_scan_scheduler: RTL and testbench

Sequencer and arbiter for the 32-channel ADG732 analog multiplexer. It scans a programmable channel window with a programmable dwell time. Single-channel manual requests are granted priority at dwell boundaries. The block generates the ADG732 CS/WR/EN strobes with guaranteed address setup and hold. It replaces free-running divider-based stepping and feeds a settled-channel strobe to downstream sampling logic.

---
 rtl/mux_scan_scheduler.sv | 169 ++++++++++++++++
 tb/tb_mux_scan_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_scheduler.sv
// rtl/mux_scan_scheduler.sv - ADG732 32-channel mux scan sequencer, manual-request arbiter and strobe generator
module mux_scan_scheduler #(
  parameter int SETUP_CYC = 2,
  parameter int WR_CYC    = 2,
  parameter int DWELL_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_en,
  input  logic [4:0]         first_ch,
  input  logic [4:0]         last_ch,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               req_valid,
  input  logic [4:0]         req_ch,
  output logic               req_ready,
  output logic               busy,
  output logic               ch_valid,
  output logic [4:0]         cur_ch,
  output logic               cs_n,
  output logic               wr_n,
  output logic               en_n,
  output logic [4:0]         addr
);

  // Phase counter covers both the SETUP and WRITE phases, so size it for the longer one.
  localparam int CNT_MAX = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    LATCH = 3'd3,
    DWELL = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_last_q, dwell_last_d;
  logic [4:0]         scan_ptr_q, scan_ptr_d;
  logic [4:0]         addr_q, addr_d;
  logic [4:0]         cur_ch_q, cur_ch_d;
  logic               ch_valid_q, ch_valid_d;
  logic               en_n_q, en_n_d;
  logic               cs_n_q, cs_n_d;
  logic               wr_n_q, wr_n_d;

  logic               dwell_final;
  logic               decision;

  // A decision cycle is where arbitration happens: any IDLE cycle or the last cycle of a dwell.
  assign dwell_final = (state_q == DWELL) && (dwell_cnt_q == dwell_last_q);
  assign decision    = (state_q == IDLE) || dwell_final;

  assign req_ready = decision && !rst;
  assign busy      = (state_q != IDLE);
  assign ch_valid  = ch_valid_q;
  assign cur_ch    = cur_ch_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign en_n      = en_n_q;
  assign addr      = addr_q;

  // Next-state logic: arbitration at decision cycles, phase sequencing and strobe generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_last_d = dwell_last_q;
    scan_ptr_d   = scan_ptr_q;
    addr_d       = addr_q;
    cur_ch_d     = cur_ch_q;
    ch_valid_d   = 1'b0;
    en_n_d       = en_n_q;

    case (state_q)
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        // The mux has latched addr on the wr_n rising edge; settling starts now.
        state_d      = DWELL;
        dwell_cnt_d  = '0;
        dwell_last_d = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));
        cur_ch_d     = addr_q;
        ch_valid_d   = 1'b1;
        en_n_d       = 1'b0;
      end
      DWELL: begin
        if (!dwell_final) begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
      default: begin
      end
    endcase

    if (decision) begin
      if (req_valid) begin
        // Manual grant: scan position is left untouched so the scan resumes where it was.
        addr_d  = req_ch;
        state_d = SETUP;
        cnt_d   = '0;
      end else if (scan_en) begin
        addr_d     = scan_ptr_q;
        scan_ptr_d = (scan_ptr_q == last_ch) ? first_ch : (scan_ptr_q + 5'd1);
        state_d    = SETUP;
        cnt_d      = '0;
      end else begin
        state_d = IDLE;
      end
    end

    // While scanning is off the pointer tracks the window start, so a new scan begins at first_ch.
    if ((state_q == IDLE) && !scan_en) begin
      scan_ptr_d = first_ch;
    end

    // Strobes are registered from the next state so they change cleanly on the clock edge.
    cs_n_d = !((state_d == SETUP) || (state_d == WRITE) || (state_d == LATCH));
    wr_n_d = !(state_d == WRITE);
  end

  // State and datapath registers with synchronous reset; reset also abandons any write in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dwell_cnt_q  <= '0;
      dwell_last_q <= '0;
      scan_ptr_q   <= '0;
      addr_q       <= '0;
      cur_ch_q     <= '0;
      ch_valid_q   <= 1'b0;
      en_n_q       <= 1'b1;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_last_q <= dwell_last_d;
      scan_ptr_q   <= scan_ptr_d;
      addr_q       <= addr_d;
      cur_ch_q     <= cur_ch_d;
      ch_valid_q   <= ch_valid_d;
      en_n_q       <= en_n_d;
      cs_n_q       <= cs_n_d;
      wr_n_q       <= wr_n_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_scheduler.sv
// tb/tb_mux_scan_scheduler.sv - self-checking bench for mux_scan_scheduler
module tb_mux_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b0;
  logic [4:0]  first_ch = '0;
  logic [4:0]  last_ch = '0;
  logic [23:0] dwell = '0;
  logic        req_valid = 1'b0;
  logic [4:0]  req_ch = '0;
  logic        req_ready, busy, ch_valid, cs_n, wr_n, en_n;
  logic [4:0]  cur_ch, addr;

  mux_scan_scheduler #(.SETUP_CYC(2), .WR_CYC(2), .DWELL_W(24)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .first_ch(first_ch), .last_ch(last_ch),
    .dwell(dwell), .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .busy(busy), .ch_valid(ch_valid), .cur_ch(cur_ch), .cs_n(cs_n), .wr_n(wr_n),
    .en_n(en_n), .addr(addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [4:0] ch;
    int         at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         dw;
    int         n;
    logic [4:0] seq [5];
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] f, input logic [4:0] l, input int d, input int n,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] s3, input logic [4:0] s4);
    vec_t v;
    v.first = f; v.last = l; v.dw = d; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [4:0] ch, input int at);
    exp_t e;
    e.ch = ch; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every ch_valid and checks strobe/address discipline.
  logic [4:0] prev_addr = '0;
  logic       prev_wr_n = 1'b1;
  logic       prev_rst  = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (ch_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_ch_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("cur_ch", int'(cur_ch), int'(e.ch));
        check("ch_valid_cycle", cyc, e.at);
      end
    end
    if (!rst && !prev_rst && (!wr_n || !prev_wr_n)) begin
      check("addr_stable_around_wr", int'(addr), int'(prev_addr));
    end
    if (!wr_n) check("cs_low_during_wr", int'(cs_n), 0);
    prev_addr = addr;
    prev_wr_n = wr_n;
    prev_rst  = rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p, last_cv, dmax;

    add_vec(5'd2,  5'd4, 3,  5, 5'd2,  5'd3,  5'd4, 5'd2, 5'd3);
    add_vec(5'd30, 5'd1, 0,  5, 5'd30, 5'd31, 5'd0, 5'd1, 5'd30);
    add_vec(5'd5,  5'd5, 1,  3, 5'd5,  5'd5,  5'd5, 5'd0, 5'd0);
    add_vec(5'd0,  5'd3, 10, 5, 5'd0,  5'd1,  5'd2, 5'd3, 5'd0);
    add_vec(5'd31, 5'd0, 2,  4, 5'd31, 5'd0,  5'd31, 5'd0, 5'd0);

    // Reset then idle.
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    wait_cyc(3);
    rst = 1'b0;
    #1;
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_wr_n", int'(wr_n), 1);
    check("rst_en_n", int'(en_n), 1);
    check("rst_addr", int'(addr), 0);
    check("rst_cur_ch", int'(cur_ch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ch_valid", int'(ch_valid), 0);
    check("idle_req_ready", int'(req_ready), 1);

    // Manual request from IDLE with scanning off.
    @(negedge clk);
    dwell = 24'd1;
    req_ch = 5'd9;
    req_valid = 1'b1;
    c = cyc;
    push_exp(5'd9, c + 6);
    wait_cyc(c + 1);
    req_valid = 1'b0;
    check("man_busy", int'(busy), 1);
    check("man_req_ready_setup", int'(req_ready), 0);
    wait_cyc(c + 5);
    check("man_en_n_before", int'(en_n), 1);
    wait_cyc(c + 6);
    check("man_en_n_after", int'(en_n), 0);
    wait_cyc(c + 7);
    check("man_idle_busy", int'(busy), 0);

    // Table-driven scan windows.
    foreach (vecs[i]) begin
      scan_en  = 1'b0;
      first_ch = vecs[i].first;
      last_ch  = vecs[i].last;
      dwell    = 24'(vecs[i].dw);
      wait_cyc(cyc + 2);
      c = cyc;
      check("scan_start_busy", int'(busy), 0);
      check("scan_start_ready", int'(req_ready), 1);
      scan_en = 1'b1;
      dmax = (vecs[i].dw == 0) ? 1 : vecs[i].dw;
      p = 5 + dmax;
      for (int k = 0; k < vecs[i].n; k++) push_exp(vecs[i].seq[k], c + 6 + k * p);
      last_cv = c + 6 + (vecs[i].n - 1) * p;
      wait_cyc(c + 1);
      check("setup_cs_n", int'(cs_n), 0);
      check("setup_wr_n", int'(wr_n), 1);
      wait_cyc(c + 2);
      check("setup_end_wr_n", int'(wr_n), 1);
      wait_cyc(c + 3);
      check("write_wr_n", int'(wr_n), 0);
      wait_cyc(c + 4);
      check("write_end_wr_n", int'(wr_n), 0);
      wait_cyc(c + 5);
      check("latch_wr_n", int'(wr_n), 1);
      check("latch_cs_n", int'(cs_n), 0);
      wait_cyc(c + 6);
      check("dwell_cs_n", int'(cs_n), 1);
      wait_cyc(last_cv - 1);
      scan_en = 1'b0;
      wait_cyc(last_cv + dmax - 1);
      check("final_dwell_busy", int'(busy), 1);
      check("final_dwell_ready", int'(req_ready), 1);
      wait_cyc(last_cv + dmax);
      check("stop_idle_busy", int'(busy), 0);
      check("scan_sb_drained", sb.size(), 0);
    end

    // Manual request held mid-dwell wins at the dwell boundary; scan resumes afterwards.
    first_ch = 5'd0;
    last_ch  = 5'd3;
    dwell    = 24'd5;
    wait_cyc(cyc + 2);
    c = cyc;
    scan_en = 1'b1;
    push_exp(5'd0, c + 6);
    push_exp(5'd1, c + 16);
    push_exp(5'd17, c + 26);
    push_exp(5'd2, c + 36);
    push_exp(5'd3, c + 46);
    wait_cyc(c + 18);
    req_ch = 5'd17;
    req_valid = 1'b1;
    check("prio_ready_mid_dwell", int'(req_ready), 0);
    wait_cyc(c + 19);
    check("prio_ready_dwell_m1", int'(req_ready), 0);
    wait_cyc(c + 20);
    check("prio_ready_final", int'(req_ready), 1);
    wait_cyc(c + 21);
    check("prio_ready_setup", int'(req_ready), 0);
    check("prio_addr", int'(addr), 17);
    req_valid = 1'b0;
    wait_cyc(c + 45);
    scan_en = 1'b0;
    wait_cyc(c + 51);
    check("prio_idle_busy", int'(busy), 0);
    check("prio_sb_drained", sb.size(), 0);

    // Reset asserted during WRITE abandons the write.
    first_ch = 5'd6;
    last_ch  = 5'd8;
    dwell    = 24'd2;
    wait_cyc(cyc + 2);
    c = cyc;
    scan_en = 1'b1;
    wait_cyc(c + 3);
    check("midwr_wr_n_low", int'(wr_n), 0);
    rst = 1'b1;
    wait_cyc(c + 4);
    check("midwr_wr_n", int'(wr_n), 1);
    check("midwr_cs_n", int'(cs_n), 1);
    check("midwr_en_n", int'(en_n), 1);
    check("midwr_cur_ch", int'(cur_ch), 0);
    check("midwr_addr", int'(addr), 0);
    check("midwr_busy", int'(busy), 0);
    check("midwr_req_ready", int'(req_ready), 0);
    scan_en = 1'b0;
    rst = 1'b0;
    wait_cyc(c + 12);
    check("post_rst_busy", int'(busy), 0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
